// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: opcode encoding and the arbiter FSM states.
// Pure type/constant package; no logic, no latency.
package alu_arb_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } arb_state_e;

  // Shifts use only the low five bits of ArgB.
  localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: y = f(op, a, b); zero latency, no flow control.
// Opcodes outside the defined set produce zero.
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt;

  assign shamt = b[SHAMT_W-1:0];
  assign lt    = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    case (op)
      OPW'(OP_ADD): y = a + b;
      OPW'(OP_SUB): y = a - b;
      OPW'(OP_AND): y = a & b;
      OPW'(OP_OR):  y = a | b;
      OPW'(OP_XOR): y = a ^ b;
      OPW'(OP_SLT): y = {{(WIDTH-1){1'b0}}, lt};
      OPW'(OP_SHL): y = a << shamt;
      OPW'(OP_SHR): y = a >> shamt;
      default:      y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters; result valid 2 cycles after grant.
// One op in flight; req_ready stays low until the response handshake (rsp_ready backpressure holds DONE).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 32,
  parameter  int OPW   = 3,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OPW-1:0]   req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  input  logic                  rsp_ready,
  output logic                  busy
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_id;
  logic [NREQ-1:0]  gnt;
  logic             gnt_any;
  logic             accept;
  logic [IDW-1:0]   id_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_y;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int ofs);
    return IDW'((int'(base) + ofs) % NREQ);
  endfunction

  // First pending requester at or above rr_ptr, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[wrap_idx(rr_ptr, k)]) begin
        gnt_any              = 1'b1;
        gnt_id               = wrap_idx(rr_ptr, k);
        gnt[gnt_id] = 1'b1;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && !Rst) ? gnt : '0;
  assign accept    = (state_q == S_IDLE) && gnt_any;
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = id_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_any) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q   <= gnt_id;
        op_q   <= req_op[int'(gnt_id)*OPW +: OPW];
        a_q    <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
        b_q    <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
        rr_ptr <= wrap_idx(gnt_id, 1);
      end
      if (state_q == S_EXEC) begin
        rsp_result <= alu_y;
        rsp_valid  <= 1'b1;
      end
      if (state_q == S_DONE && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu_core (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant order, ALU results, latency, backpressure and reset abort.
module tb_alu_arbiter;

  logic         Clk;
  logic         Rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [11:0]  req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_ready;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.NREQ(4), .WIDTH(32), .OPW(3)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[id*3 +: 3]  = op;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
  endtask

  // Grant cycle, EXEC cycle, DONE cycle; returns in DONE with the handshake due on the next edge.
  task automatic do_op(input string tag, input logic [3:0] mask, input int id, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    @(negedge Clk);
    req_valid = mask;
    set_req(id, op, a, b);
    #1 chk({tag, ".ready"}, 32'(req_ready), 32'(onehot));
    @(negedge Clk);
    req_valid = '0;
    set_req(id, ~op, ~a, b + 32'd3);
    #1 chk({tag, ".exec_vld"}, 32'(rsp_valid), 32'd0);
    @(negedge Clk);
    #1;
    chk({tag, ".vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".result"}, rsp_result, exp);
    chk({tag, ".id"}, 32'(rsp_id), 32'(id));
  endtask

  initial begin
    logic [3:0] exp_rdy;
    Rst       = 1'b1;
    req_valid = 4'b1111;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests pending
    @(negedge Clk);
    @(negedge Clk);
    #1;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.vld", 32'(rsp_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.id", 32'(rsp_id), 32'd0);
    chk("rst.result", rsp_result, 32'd0);

    @(negedge Clk);
    Rst       = 1'b0;
    req_valid = '0;

    // Single request with wrap-around ADD; operands scrambled after accept
    do_op("add_wrap", 4'b0100, 2, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    do_op("slt_neg", 4'b0010, 1, 3'd5, 32'h8000_0000, 32'd1, 32'd1);
    do_op("shr31", 4'b0001, 0, 3'd7, 32'h8000_0000, 32'd31, 32'd1);
    do_op("sub_wrap", 4'b1000, 3, 3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    do_op("and", 4'b0100, 2, 3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    do_op("or", 4'b0010, 1, 3'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    do_op("xor", 4'b0001, 0, 3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    do_op("shl_lo5", 4'b1000, 3, 3'd6, 32'd1, 32'h0000_0024, 32'h0000_0010);
    do_op("slt_pos", 4'b0100, 2, 3'd5, 32'd1, 32'h8000_0000, 32'd0);
    do_op("add", 4'b0010, 1, 3'd0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);

    // Requester withdrawing before the edge is never granted
    @(negedge Clk);
    req_valid = 4'b0001;
    #1 chk("withdraw.ready_on", 32'(req_ready), 32'd1);
    req_valid = 4'b0000;
    #1 chk("withdraw.ready_off", 32'(req_ready), 32'd0);
    @(negedge Clk);
    #1 chk("withdraw.busy", 32'(busy), 32'd0);

    // Round robin from reset with all requesters valid: grants 0,1,2,3,0
    Rst       = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 3'd0, 32'(i * 16), 32'd1);
    #1 chk("rr.rst_ready", 32'(req_ready), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      exp_rdy = (k % 3 == 0) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
      chk($sformatf("rr.ready[%0d]", k), 32'(req_ready), 32'(exp_rdy));
      if (k % 3 == 2) begin
        chk($sformatf("rr.id[%0d]", k), 32'(rsp_id), 32'((k / 3) % 4));
        chk($sformatf("rr.res[%0d]", k), rsp_result, 32'(((k / 3) % 4) * 16 + 1));
      end
      @(negedge Clk);
    end

    // Backpressure: DONE held 5 cycles with every requester pending
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_req(3, 3'd0, 32'd5, 32'd7);
    #1 chk("bp.ready", 32'(req_ready), 32'b1000);
    @(negedge Clk);
    req_valid = 4'b1111;
    set_req(3, 3'd1, 32'd100, 32'd1);
    #1 chk("bp.exec_vld", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      #1;
      chk($sformatf("bp.vld[%0d]", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp.result[%0d]", k), rsp_result, 32'd12);
      chk($sformatf("bp.id[%0d]", k), 32'(rsp_id), 32'd3);
      chk($sformatf("bp.ready[%0d]", k), 32'(req_ready), 32'd0);
    end
    @(negedge Clk);
    rsp_ready = 1'b1;
    #1 chk("bp.vld_last", 32'(rsp_valid), 32'd1);
    @(negedge Clk);
    #1;
    chk("bp.regrant", 32'(req_ready), 32'b0001);
    chk("bp.vld_clear", 32'(rsp_valid), 32'd0);
    req_valid = '0;

    // Reset during EXEC discards the operation and clears rr_ptr
    @(negedge Clk);
    req_valid = 4'b0100;
    set_req(2, 3'd0, 32'd1, 32'd1);
    #1 chk("abort.ready", 32'(req_ready), 32'b0100);
    @(negedge Clk);
    #1 chk("abort.busy_exec", 32'(busy), 32'd1);
    Rst       = 1'b1;
    req_valid = '0;
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("abort.vld[%0d]", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("abort.busy[%0d]", k), 32'(busy), 32'd0);
      @(negedge Clk);
    end
    do_op("abort.next", 4'b1010, 1, 3'd4, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_0FF0);

    @(negedge Clk);
    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
